// File: rtl/g_matched_filter_acc.sv
// g_matched_filter_acc
// Buffers one 4-sample received vector y, then correlates it against the four
// streamed rows of Ga1/Ga2/Gb1/Gb2. Each (matrix, column) pair accumulates
// z[c] = sum_i conj(G[i][c]) * y[i]. Each completed burst produces one rescaled,
// saturated result set.
// Optional build macro: MF_ROUND_EN selects round-half-up before the rescale.
// Without it, the rescale truncates toward minus infinity.
// Matrix index order used internally: 0=a1, 1=a2, 2=b1, 3=b2.
module g_matched_filter_acc #(
   parameter int N    = 16,
   parameter int FRAC = N - 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         y_in_valid,
   input  logic [N-1:0] y_in_r,
   input  logic [N-1:0] y_in_i,
   output logic         y_ready,
   input  logic         G_valid,
   input  logic [N-1:0] Ga1_c0_r, Ga1_c0_i, Ga1_c1_r, Ga1_c1_i,
   input  logic [N-1:0] Ga2_c0_r, Ga2_c0_i, Ga2_c1_r, Ga2_c1_i,
   input  logic [N-1:0] Gb1_c0_r, Gb1_c0_i, Gb1_c1_r, Gb1_c1_i,
   input  logic [N-1:0] Gb2_c0_r, Gb2_c0_i, Gb2_c1_r, Gb2_c1_i,
   output logic         z_valid,
   output logic [N-1:0] z_a1_c0_r, z_a1_c0_i, z_a1_c1_r, z_a1_c1_i,
   output logic [N-1:0] z_a2_c0_r, z_a2_c0_i, z_a2_c1_r, z_a2_c1_i,
   output logic [N-1:0] z_b1_c0_r, z_b1_c0_i, z_b1_c1_r, z_b1_c1_i,
   output logic [N-1:0] z_b2_c0_r, z_b2_c0_i, z_b2_c1_r, z_b2_c1_i,
   output logic         err
);

   localparam int AW = 2 * N + 3;
   localparam logic signed [AW-1:0] ZMAX = AW'((2 ** (N - 1)) - 1);
   localparam logic signed [AW-1:0] ZMIN = -ZMAX - AW'(1);
`ifdef MF_ROUND_EN
   localparam logic signed [AW-1:0] RND = AW'(2 ** (FRAC - 1));
`endif

   typedef enum logic [1:0] {LOAD, READY, ACC} state_t;

   state_t state, state_nxt;
   logic [1:0] y_cnt, row_cnt;
   logic y_wr, row_first, row_mid, row_last, abort, load_err;
   logic signed [N-1:0]  y_buf_r [4];
   logic signed [N-1:0]  y_buf_i [4];
   logic signed [N-1:0]  g_r   [4][2];
   logic signed [N-1:0]  g_i   [4][2];
   logic signed [AW-1:0] p_r   [4][2];
   logic signed [AW-1:0] p_i   [4][2];
   logic signed [AW-1:0] acc_r [4][2];
   logic signed [AW-1:0] acc_i [4][2];
   logic signed [N-1:0]  z_r   [4][2];
   logic signed [N-1:0]  z_i   [4][2];

   // Computes a*b + c*d, or a*b - c*d when neg is set.
   // Each product is full width; the result is widened to accumulator width.
   function automatic logic signed [AW-1:0] cmac(input logic signed [N-1:0] a, b, c, d,
                                                 input logic neg);
      logic signed [2*N-1:0] ab, cd;
      ab = (2*N)'(a) * (2*N)'(b);
      cd = (2*N)'(c) * (2*N)'(d);
      if (neg) return AW'(ab) - AW'(cd);
      else     return AW'(ab) + AW'(cd);
   endfunction

   // Rescales an accumulator from the product format back to the y/z format.
   // The result is then clamped to the N-bit signed range.
   function automatic logic signed [N-1:0] rescale(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] t;
`ifdef MF_ROUND_EN
      t = v + RND;
`else
      t = v;
`endif
      t = t >>> FRAC;
      if (t > ZMAX)      return ZMAX[N-1:0];
      else if (t < ZMIN) return ZMIN[N-1:0];
      else               return t[N-1:0];
   endfunction

   assign g_r[0][0] = Ga1_c0_r;  assign g_i[0][0] = Ga1_c0_i;
   assign g_r[0][1] = Ga1_c1_r;  assign g_i[0][1] = Ga1_c1_i;
   assign g_r[1][0] = Ga2_c0_r;  assign g_i[1][0] = Ga2_c0_i;
   assign g_r[1][1] = Ga2_c1_r;  assign g_i[1][1] = Ga2_c1_i;
   assign g_r[2][0] = Gb1_c0_r;  assign g_i[2][0] = Gb1_c0_i;
   assign g_r[2][1] = Gb1_c1_r;  assign g_i[2][1] = Gb1_c1_i;
   assign g_r[3][0] = Gb2_c0_r;  assign g_i[3][0] = Gb2_c0_i;
   assign g_r[3][1] = Gb2_c1_r;  assign g_i[3][1] = Gb2_c1_i;

   assign z_a1_c0_r = z_r[0][0]; assign z_a1_c0_i = z_i[0][0];
   assign z_a1_c1_r = z_r[0][1]; assign z_a1_c1_i = z_i[0][1];
   assign z_a2_c0_r = z_r[1][0]; assign z_a2_c0_i = z_i[1][0];
   assign z_a2_c1_r = z_r[1][1]; assign z_a2_c1_i = z_i[1][1];
   assign z_b1_c0_r = z_r[2][0]; assign z_b1_c0_i = z_i[2][0];
   assign z_b1_c1_r = z_r[2][1]; assign z_b1_c1_i = z_i[2][1];
   assign z_b2_c0_r = z_r[3][0]; assign z_b2_c0_i = z_i[3][0];
   assign z_b2_c1_r = z_r[3][1]; assign z_b2_c1_i = z_i[3][1];

   // State register for the load / wait / accumulate sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic and per-cycle control strobes.
   // In each state, only the input that state cares about takes effect.
   always_comb begin
      state_nxt = state;
      y_wr      = 1'b0;
      row_first = 1'b0;
      row_mid   = 1'b0;
      row_last  = 1'b0;
      abort     = 1'b0;
      load_err  = 1'b0;
      case (state)
         LOAD: begin
            if (y_in_valid) begin
               y_wr = 1'b1;
               if (y_cnt == 2'd3) state_nxt = READY;
            end else if (G_valid) begin
               load_err = 1'b1;
            end
         end
         READY: begin
            if (G_valid) begin
               row_first = 1'b1;
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (G_valid) begin
               if (row_cnt == 2'd3) begin
                  row_last  = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  row_mid = 1'b1;
               end
            end else begin
               abort     = 1'b1;
               state_nxt = READY;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Forms conj(G) * y[row] for every matrix/column from the current row and the buffered sample.
   always_comb begin
      for (int m = 0; m < 4; m++) begin
         for (int c = 0; c < 2; c++) begin
            p_r[m][c] = cmac(g_r[m][c], y_buf_r[row_cnt], g_i[m][c], y_buf_i[row_cnt], 1'b0);
            p_i[m][c] = cmac(g_r[m][c], y_buf_i[row_cnt], g_i[m][c], y_buf_r[row_cnt], 1'b1);
         end
      end
   end

   // Datapath registers: y buffer, counters, accumulators, held results and status pulses.
   // Row 0 overwrites the accumulators, so an aborted burst needs no explicit clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_cnt   <= 2'd0;
         row_cnt <= 2'd0;
         y_ready <= 1'b0;
         z_valid <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            y_buf_r[i] <= '0;
            y_buf_i[i] <= '0;
         end
         for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 2; c++) begin
               acc_r[m][c] <= '0;
               acc_i[m][c] <= '0;
               z_r[m][c]   <= '0;
               z_i[m][c]   <= '0;
            end
         end
      end else begin
         y_ready <= (state_nxt == READY);
         z_valid <= row_last;
         err     <= load_err | abort;
         if (y_wr) begin
            y_buf_r[y_cnt] <= y_in_r;
            y_buf_i[y_cnt] <= y_in_i;
            y_cnt          <= y_cnt + 2'd1;
         end
         if (row_first)              row_cnt <= 2'd1;
         else if (row_mid)           row_cnt <= row_cnt + 2'd1;
         else if (row_last || abort) row_cnt <= 2'd0;
         if (row_last) y_cnt <= 2'd0;
         for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 2; c++) begin
               if (row_first) begin
                  acc_r[m][c] <= p_r[m][c];
                  acc_i[m][c] <= p_i[m][c];
               end else if (row_mid) begin
                  acc_r[m][c] <= acc_r[m][c] + p_r[m][c];
                  acc_i[m][c] <= acc_i[m][c] + p_i[m][c];
               end
               if (row_last) begin
                  z_r[m][c] <= rescale(acc_r[m][c] + p_r[m][c]);
                  z_i[m][c] <= rescale(acc_i[m][c] + p_i[m][c]);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_g_matched_filter_acc.sv
// Testbench for g_matched_filter_acc (N=16, FRAC=14).
// It runs a hand-computed vector table, then the protocol-error and reset sequences.
// After that come randomized bursts.
// Every expected value comes from hand-computed constants or from the reference model below.
module tb_g_matched_filter_acc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic y_in_valid = 1'b0;
   logic G_valid = 1'b0;
   logic [15:0] y_in_r = '0;
   logic [15:0] y_in_i = '0;
   logic [15:0] gr [4][2];
   logic [15:0] gi [4][2];
   logic y_ready, z_valid, err;
   logic signed [15:0] zr [4][2];
   logic signed [15:0] zi [4][2];

   int checks = 0;
   int failures = 0;

   int yR [4];
   int yI [4];
   int gRm [4][4][2];
   int gIm [4][4][2];

   typedef struct {
      string name;
      int y0r, y0i, ynr, yni;
      int m, c;
      int g0r, g0i, gnr, gni;
      int er, ei;
   } vec_t;
   vec_t vecs [8];

   g_matched_filter_acc #(.N(16), .FRAC(14)) dut (
      .clk(clk), .rst(rst),
      .y_in_valid(y_in_valid), .y_in_r(y_in_r), .y_in_i(y_in_i), .y_ready(y_ready),
      .G_valid(G_valid),
      .Ga1_c0_r(gr[0][0]), .Ga1_c0_i(gi[0][0]), .Ga1_c1_r(gr[0][1]), .Ga1_c1_i(gi[0][1]),
      .Ga2_c0_r(gr[1][0]), .Ga2_c0_i(gi[1][0]), .Ga2_c1_r(gr[1][1]), .Ga2_c1_i(gi[1][1]),
      .Gb1_c0_r(gr[2][0]), .Gb1_c0_i(gi[2][0]), .Gb1_c1_r(gr[2][1]), .Gb1_c1_i(gi[2][1]),
      .Gb2_c0_r(gr[3][0]), .Gb2_c0_i(gi[3][0]), .Gb2_c1_r(gr[3][1]), .Gb2_c1_i(gi[3][1]),
      .z_valid(z_valid),
      .z_a1_c0_r(zr[0][0]), .z_a1_c0_i(zi[0][0]), .z_a1_c1_r(zr[0][1]), .z_a1_c1_i(zi[0][1]),
      .z_a2_c0_r(zr[1][0]), .z_a2_c0_i(zi[1][0]), .z_a2_c1_r(zr[1][1]), .z_a2_c1_i(zi[1][1]),
      .z_b1_c0_r(zr[2][0]), .z_b1_c0_i(zi[2][0]), .z_b1_c1_r(zr[2][1]), .z_b1_c1_i(zi[2][1]),
      .z_b2_c0_r(zr[3][0]), .z_b2_c0_i(zi[3][0]), .z_b2_c1_r(zr[3][1]), .z_b2_c1_i(zi[3][1]),
      .err(err)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Advances to just after the next rising edge, where inputs are driven and outputs sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the complex correlation sum_i conj(G[i]) * y[i] in plain integers.
   // The sum is then scaled by 2^-14 (floor, or round half up) and clamped to 16 bits.
   function automatic int model(input int m, input int c, input bit im);
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
         if (!im) s += longint'(gRm[i][m][c]) * yR[i] + longint'(gIm[i][m][c]) * yI[i];
         else     s += longint'(gRm[i][m][c]) * yI[i] - longint'(gIm[i][m][c]) * yR[i];
      end
`ifdef MF_ROUND_EN
      s += 8192;
`endif
      s = s >>> 14;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   function automatic int rand16();
      int v;
      v = int'($urandom_range(0, 65535)) - 32768;
      return v >>> $urandom_range(0, 3);
   endfunction

   task automatic clearG();
      for (int r = 0; r < 4; r++)
         for (int m = 0; m < 4; m++)
            for (int c = 0; c < 2; c++) begin
               gRm[r][m][c] = 0;
               gIm[r][m][c] = 0;
            end
   endtask

   task automatic randomizeG();
      for (int r = 0; r < 4; r++)
         for (int m = 0; m < 4; m++)
            for (int c = 0; c < 2; c++) begin
               gRm[r][m][c] = rand16();
               gIm[r][m][c] = rand16();
            end
   endtask

   task automatic driveRow(input int r);
      G_valid = 1'b1;
      for (int m = 0; m < 4; m++)
         for (int c = 0; c < 2; c++) begin
            gr[m][c] = gRm[r][m][c][15:0];
            gi[m][c] = gIm[r][m][c][15:0];
         end
   endtask

   // Loads y[lo..hi]. y_ready must rise exactly after y[3] is accepted.
   task automatic loadRange(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         y_in_valid = 1'b1;
         y_in_r = yR[i][15:0];
         y_in_i = yI[i][15:0];
         tick();
         checkOutput($sformatf("y_ready_after_y%0d", i), int'(y_ready), (i == 3) ? 1 : 0);
      end
      y_in_valid = 1'b0;
   endtask

   // Streams rows 0..3 back to back, then checks the z_valid pulse and all 16 results.
   // Optionally drives y_in_valid during row 3; the DUT must ignore it.
   task automatic applyStimulus(input bit yOnLast);
      for (int r = 0; r < 4; r++) begin
         driveRow(r);
         if (r == 3 && yOnLast) begin
            y_in_valid = 1'b1;
            y_in_r = 16'h1234;
         end
         tick();
         if (r < 3) checkOutput($sformatf("z_valid_row%0d", r), int'(z_valid), 0);
      end
      G_valid = 1'b0;
      y_in_valid = 1'b0;
      checkOutput("z_valid_pulse", int'(z_valid), 1);
      checkOutput("y_ready_after_burst", int'(y_ready), 0);
      for (int m = 0; m < 4; m++)
         for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("z_r[%0d][%0d]", m, c), int'(zr[m][c]), model(m, c, 1'b0));
            checkOutput($sformatf("z_i[%0d][%0d]", m, c), int'(zi[m][c]), model(m, c, 1'b1));
         end
      tick();
      checkOutput("z_valid_single", int'(z_valid), 0);
      checkOutput("err_idle", int'(err), 0);
   endtask

   initial begin
      int rp, rn;
`ifdef MF_ROUND_EN
      rp = 1; rn = 0;
`else
      rp = 0; rn = -1;
`endif
      vecs[0] = '{"unit_a1_c0",  4096, 0, 4096, 0,     0, 0, 16384, 0, 16384, 0,   16384, 0};
      vecs[1] = '{"conj_b2_c1",  0, 4096, 0, 4096,     3, 1, 0, 16384, 0, 16384,   16384, 0};
      vecs[2] = '{"satpos_a2",   32767, 0, 32767, 0,   1, 0, 32767, 0, 32767, 0,   32767, 0};
      vecs[3] = '{"satneg_a2",   32767, 0, 32767, 0,   1, 0, -32768, 0, -32768, 0, -32768, 0};
      vecs[4] = '{"row0_pos",    1, 0, 0, 0,           0, 0, 8192, 0, 0, 0,        rp, 0};
      vecs[5] = '{"row0_neg",    -1, 0, 0, 0,          0, 0, 8192, 0, 0, 0,        rn, 0};
      vecs[6] = '{"sat_b1_c1",   4096, 4096, 4096, 4096, 2, 1, 16384, 16384, 16384, 16384, 32767, 0};
      vecs[7] = '{"imag_a1_c1",  4096, 0, 4096, 0,     0, 1, 0, 16384, 0, 16384,   0, -16384};

      for (int m = 0; m < 4; m++)
         for (int c = 0; c < 2; c++) begin
            gr[m][c] = '0;
            gi[m][c] = '0;
         end

      // Reset state, sampled while reset is still held.
      #12;
      checkOutput("reset_y_ready", int'(y_ready), 0);
      checkOutput("reset_z_valid", int'(z_valid), 0);
      checkOutput("reset_err", int'(err), 0);
      checkOutput("reset_z_a1_c0_r", int'(zr[0][0]), 0);
      checkOutput("reset_z_b2_c1_i", int'(zi[3][1]), 0);
      #1 rst = 1'b0;
      tick();

      // Hand-computed vector table.
      foreach (vecs[k]) begin
         clearG();
         for (int i = 0; i < 4; i++) begin
            yR[i] = (i == 0) ? vecs[k].y0r : vecs[k].ynr;
            yI[i] = (i == 0) ? vecs[k].y0i : vecs[k].yni;
            gRm[i][vecs[k].m][vecs[k].c] = (i == 0) ? vecs[k].g0r : vecs[k].gnr;
            gIm[i][vecs[k].m][vecs[k].c] = (i == 0) ? vecs[k].g0i : vecs[k].gni;
         end
         loadRange(0, 3);
         applyStimulus(1'b0);
         checkOutput({vecs[k].name, "_r"}, int'(zr[vecs[k].m][vecs[k].c]), vecs[k].er);
         checkOutput({vecs[k].name, "_i"}, int'(zi[vecs[k].m][vecs[k].c]), vecs[k].ei);
      end

      // G_valid while loading: err pulse, no result, load position kept.
      for (int i = 0; i < 4; i++) begin
         yR[i] = rand16();
         yI[i] = rand16();
      end
      randomizeG();
      loadRange(0, 1);
      driveRow(0);
      tick();
      G_valid = 1'b0;
      checkOutput("load_g_err", int'(err), 1);
      checkOutput("load_g_no_z", int'(z_valid), 0);
      checkOutput("load_g_y_ready", int'(y_ready), 0);
      tick();
      checkOutput("load_g_err_pulse", int'(err), 0);
      loadRange(2, 3);

      // Gap after row 1: err pulse, back to waiting with y kept.
      driveRow(0);
      tick();
      driveRow(1);
      tick();
      G_valid = 1'b0;
      tick();
      checkOutput("gap_err", int'(err), 1);
      checkOutput("gap_y_ready", int'(y_ready), 1);
      checkOutput("gap_no_z", int'(z_valid), 0);
      tick();
      checkOutput("gap_err_pulse", int'(err), 0);
      randomizeG();
      applyStimulus(1'b0);

      // Reset in the middle of a burst.
      for (int i = 0; i < 4; i++) begin
         yR[i] = rand16();
         yI[i] = rand16();
      end
      loadRange(0, 3);
      driveRow(0);
      tick();
      driveRow(1);
      tick();
      G_valid = 1'b0;
      rst = 1'b1;
      #2;
      checkOutput("rst_y_ready", int'(y_ready), 0);
      checkOutput("rst_z_valid", int'(z_valid), 0);
      checkOutput("rst_err", int'(err), 0);
      for (int m = 0; m < 4; m++)
         for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("rst_z_r[%0d][%0d]", m, c), int'(zr[m][c]), 0);
            checkOutput($sformatf("rst_z_i[%0d][%0d]", m, c), int'(zi[m][c]), 0);
         end
      #2 rst = 1'b0;
      tick();
      loadRange(0, 3);
      randomizeG();
      applyStimulus(1'b0);

      // Randomized bursts. Odd iterations also drive y on the final-row edge.
      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 4; i++) begin
            yR[i] = rand16();
            yI[i] = rand16();
         end
         loadRange(0, 3);
         randomizeG();
         applyStimulus(it[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
